fb_port_arbiter: RTL
====================

// Module: fb_port_arbiter
//
// PURPOSE
//   Shares one single-port frame-buffer BRAM between the capture write stream and the display read stream.
//   Capture writes cannot stall and always win the port. Display reads run only in free cycles, and only
//   when the output FIFO is not almost-full. Reads are held off until one full frame has been written.
//   Read data is pushed into the 125->25 MHz display FIFO.
//
// PARAMETERS
//   DATA_WIDTH   12      pixel width (RGB444)
//   BRAM_DEPTH   307200  pixels per frame (640x480); both address counters wrap at BRAM_DEPTH-1
//   ADDR_WIDTH   19      BRAM address width; must satisfy 2**ADDR_WIDTH >= BRAM_DEPTH
//   RD_LATENCY   1       BRAM read latency in cycles (1 or 2)
//
// PORTS
//   i_clk           in   1           system clock (125 MHz)
//   i_rst           in   1           synchronous reset, active-high
//   i_flush         in   1           synchronous flush: same effect as i_rst
//   i_wr_valid      in   1           capture pixel valid; accepted unconditionally
//   i_wr_data       in   DATA_WIDTH  capture pixel
//   i_rd_en         in   1           display requests pixels (display active)
//   i_almostfull    in   1           display FIFO almost-full
//   o_mem_en        out  1           BRAM port enable
//   o_mem_we        out  1           BRAM write enable
//   o_mem_addr      out  ADDR_WIDTH  BRAM address
//   o_mem_wdata     out  DATA_WIDTH  BRAM write data
//   i_mem_rdata     in   DATA_WIDTH  BRAM read data
//   o_wr            out  1           display FIFO write enable
//   o_wdata         out  DATA_WIDTH  display FIFO write data (= i_mem_rdata)
//   o_wr_frame      out  1           1-cycle pulse: write of address BRAM_DEPTH-1 issued
//   o_rd_frame      out  1           1-cycle pulse: read of address BRAM_DEPTH-1 issued
//   o_state         out  2           FSM state (status/debug)
//
// BEHAVIOUR
//   - Reset/flush: all registered outputs, both address counters, the read pipeline and o_state
//     clear to 0; state goes to IDLE. Flush takes priority over every other event in that cycle.
//   - FSM states: IDLE=0, FILL=1, RUN=2.
//     * IDLE -> FILL on the first i_wr_valid (write to address 0 in that cycle).
//     * FILL -> RUN in the cycle after the write to BRAM_DEPTH-1.
//     * RUN holds until reset or flush.
//   - Write grant: gw = i_wr_valid in every state.
//     * Drives o_mem_en=1, o_mem_we=1, o_mem_addr=waddr, o_mem_wdata=i_wr_data, all combinationally.
//     * Then waddr <= (waddr==BRAM_DEPTH-1) ? 0 : waddr+1.
//   - Read grant: gr = (state==RUN) & i_rd_en & !i_almostfull & !i_wr_valid.
//     * Drives o_mem_en=1, o_mem_we=0, o_mem_addr=raddr.
//     * Then raddr wraps the same way as waddr.
//     * On collision the write wins and raddr holds.
//     * A read never issues in IDLE or FILL.
//   - Neither grant: o_mem_en=0, o_mem_we=0; o_mem_addr is don't-care.
//   - Read pipeline: gr is delayed through an RD_LATENCY-deep shift register to give o_wr.
//     * o_wdata passes i_mem_rdata straight through.
//     * Reads already in flight still deliver after i_almostfull rises. The FIFO margin must cover
//       RD_LATENCY entries.
//   - o_wr_frame/o_rd_frame: registered, high the cycle after the last-address access is granted.
//   - i_rd_en low: raddr holds; no realignment. The frame position is kept by the wrap only.
//   - No tearing protection in RUN; reads may overtake writes.
//
// TESTING
//   (all with BRAM_DEPTH=16, RD_LATENCY=1)
//   1. Hold i_rst 2 cycles mid-traffic -> o_mem_en=o_wr=0, o_state=0, next write goes to addr 0.
//   2. 16 back-to-back writes (data 0..15) with i_rd_en=1:
//      -> no read during FILL; o_wr_frame high 1 cycle after the 16th write; o_state=2 next cycle.
//   3. RUN, i_rd_en=1, no writes:
//      -> reads at addr 0..15 on consecutive cycles; o_wr one cycle later carrying 0..15;
//         o_rd_frame pulses after addr 15; raddr wraps to 0.
//   4. RUN, i_wr_valid and a read request in the same cycle at raddr=5:
//      -> write granted, raddr stays 5; the read of 5 issues on the next write-free cycle.
//   5. i_almostfull rises while a read is in flight:
//      -> that o_wr still pulses; no new grant until i_almostfull falls; raddr continues with no gap.
//   6. i_flush at waddr=7 during FILL:
//      -> next cycle state IDLE, waddr=raddr=0, no o_wr; the next i_wr_valid writes addr 0.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: capture writes always win the port,
// display reads fill the free cycles once a whole frame has been captured.
module fb_port_arbiter #(
    parameter int DATA_WIDTH = 12,
    parameter int BRAM_DEPTH = 307200,
    parameter int ADDR_WIDTH = 19,
    parameter int RD_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_wr_valid,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic                  i_almostfull,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_wr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_wr_frame,
    output logic                  o_rd_frame,
    output logic [1:0]            o_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(BRAM_DEPTH - 1);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   waddr, raddr;
    logic [RD_LATENCY-1:0]   vld_pipe;
    logic [RD_LATENCY:0]     vld_pipe_nxt;
    logic                    kill, gw, gr;

    // Grants are suppressed while reset/flush is asserted so nothing touches the BRAM.
    assign kill         = i_rst | i_flush;
    assign gw           = i_wr_valid & ~kill;
    assign gr           = (state == RUN) & i_rd_en & ~i_almostfull & ~i_wr_valid & ~kill;
    assign vld_pipe_nxt = {vld_pipe, gr};

    always_comb begin
        state_nxt   = state;
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = raddr;
        o_mem_wdata = i_wr_data;
        case (state)
            IDLE:    if (gw) state_nxt = FILL;
            FILL:    if (gw && waddr == LAST) state_nxt = RUN;
            default: state_nxt = state;
        endcase
        if (gw) begin
            o_mem_en   = 1'b1;
            o_mem_we   = 1'b1;
            o_mem_addr = waddr;
        end else if (gr) begin
            o_mem_en   = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (kill) begin
            state      <= IDLE;
            waddr      <= '0;
            raddr      <= '0;
            vld_pipe   <= '0;
            o_wr_frame <= 1'b0;
            o_rd_frame <= 1'b0;
        end else begin
            state      <= state_nxt;
            vld_pipe   <= vld_pipe_nxt[RD_LATENCY-1:0];
            o_wr_frame <= gw && (waddr == LAST);
            o_rd_frame <= gr && (raddr == LAST);
            if (gw) waddr <= (waddr == LAST) ? '0 : waddr + 1'b1;
            if (gr) raddr <= (raddr == LAST) ? '0 : raddr + 1'b1;
        end
    end

    assign o_wr    = vld_pipe[RD_LATENCY-1];
    assign o_wdata = i_mem_rdata;
    assign o_state = state;

endmodule
